// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: fetches 32-bit big-endian words and hands
// 16-bit ops with their PC to the decoder over a valid/ready stream.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush, flush_pc redirect; restart fetching at flush_pc (bit0 ignored)
//   fq_req/fq_addr  word fetch request, held until fq_ack
//   fq_rvld/rdata   fetch return; [31:16] is the op at the lower address
//   op_vld/op/op_pc head op of the queue and its PC
//   op_rdy          decoder takes the head op
//   busy            a fetch is accepted but its data has not returned
module if_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [AW-1:0] flush_pc,
    output logic          fq_req,
    output logic [AW-1:0] fq_addr,
    input  logic          fq_ack,
    input  logic          fq_rvld,
    input  logic [31:0]   fq_rdata,
    output logic          op_vld,
    output logic [15:0]   op,
    output logic [AW-1:0] op_pc,
    input  logic          op_rdy,
    output logic          busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] space;
    logic [CW-1:0] need;
    logic [CW-1:0] npush;
    logic [AW-1:0] head_pc;
    logic [AW-1:0] addr_q;
    logic          busy_q;
    logic          active;
    logic          skip;
    logic          discard;
    logic          accept;
    logic          pop;
    logic          take;
    logic          unused_pc_bit;

    assign unused_pc_bit = flush_pc[0];

    // Room for the whole word is reserved before issuing, so the
    // returning data can always be pushed without a full check.
    assign space  = DEPTH_C - count;
    assign need   = skip ? CW'(1) : CW'(2);
    assign fq_req = active & ~busy_q & ~discard & (space >= need);
    assign accept = fq_req & fq_ack;

    assign op_vld = (count != '0);
    assign op     = op_vld ? mem[rd_ptr] : 16'h0000;
    assign op_pc  = head_pc;
    assign fq_addr = addr_q;
    assign busy   = busy_q;

    assign pop   = op_vld & op_rdy & ~flush;
    assign take  = fq_rvld & busy_q & ~discard & ~flush;
    assign npush = ~take ? CW'(0) : (skip ? CW'(1) : CW'(2));

    always_ff @(posedge clk) begin
        if (take) begin
            if (skip) begin
                mem[wr_ptr] <= fq_rdata[15:0];
            end else begin
                mem[wr_ptr]          <= fq_rdata[31:16];
                mem[wr_ptr + PW'(1)] <= fq_rdata[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head_pc <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            active  <= 1'b0;
            skip    <= 1'b0;
            discard <= 1'b0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head_pc <= {flush_pc[AW-1:1], 1'b0};
            addr_q  <= {flush_pc[AW-1:2], 2'b00};
            skip    <= flush_pc[1];
            active  <= 1'b1;
            // A fetch still in flight (or accepted right now) returns
            // stale data; drop it. If it returns in this very cycle it
            // is already gone and nothing is left to drop.
            discard <= (busy_q & ~fq_rvld) | accept;
            busy_q  <= (busy_q & ~fq_rvld) | accept;
        end else begin
            if (accept) begin
                busy_q <= 1'b1;
            end
            if (fq_rvld && busy_q) begin
                busy_q  <= 1'b0;
                discard <= 1'b0;
            end
            if (take) begin
                wr_ptr <= skip ? wr_ptr + PW'(1) : wr_ptr + PW'(2);
                addr_q <= addr_q + AW'(4);
                skip   <= 1'b0;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                head_pc <= head_pc + AW'(2);
            end
            count <= count + npush - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= DEPTH_C)
            else $error("prefetch queue count exceeds DEPTH");
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: directed scenarios plus a
// randomized run against a queue-of-PCs reference model.
module tb_if_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic          fq_req;
    logic [AW-1:0] fq_addr;
    logic          fq_ack;
    logic          fq_rvld;
    logic [31:0]   fq_rdata;
    logic          op_vld;
    logic [15:0]   op;
    logic [AW-1:0] op_pc;
    logic          op_rdy;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_prefetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
        .fq_req(fq_req), .fq_addr(fq_addr), .fq_ack(fq_ack),
        .fq_rvld(fq_rvld), .fq_rdata(fq_rdata), .op_vld(op_vld),
        .op(op), .op_pc(op_pc), .op_rdy(op_rdy), .busy(busy)
    );

    function automatic logic [15:0] op_at(input logic [31:0] pc);
        return pc[15:0] ^ 16'h5A3C ^ {pc[23:16], pc[31:24]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; flush_pc = '0; fq_ack = 0;
        fq_rvld = 0; fq_rdata = '0; op_rdy = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; tick(); tick();
        rst = 0; tick(); tick();
        n_cmp++; if (fq_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", fq_req); end
        n_cmp++; if (fq_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", fq_addr); end
        n_cmp++; if (op_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", op_vld); end
        n_cmp++; if (op !== 16'h0) begin n_err++; $display("FAIL reset_op got %h want 0", op); end
        n_cmp++; if (op_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", op_pc); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        flush = 1; flush_pc = 32'h100; tick(); idle();
        n_cmp++; if (fq_req !== 1'b1) begin n_err++; $display("FAIL basic_req got %b want 1", fq_req); end
        n_cmp++; if (fq_addr !== 32'h100) begin n_err++; $display("FAIL basic_addr got %h want 100", fq_addr); end
        fq_ack = 1; tick(); idle();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", busy); end
        n_cmp++; if (fq_req !== 1'b0) begin n_err++; $display("FAIL basic_req_busy got %b want 0", fq_req); end
        tick();
        fq_rvld = 1; fq_rdata = 32'h11112222; tick(); idle();
        n_cmp++; if (op_vld !== 1'b1) begin n_err++; $display("FAIL basic_vld got %b want 1", op_vld); end
        n_cmp++; if (op !== 16'h1111) begin n_err++; $display("FAIL basic_op0 got %h want 1111", op); end
        n_cmp++; if (op_pc !== 32'h100) begin n_err++; $display("FAIL basic_pc0 got %h want 100", op_pc); end
        n_cmp++; if (fq_addr !== 32'h104) begin n_err++; $display("FAIL basic_next got %h want 104", fq_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle got %b want 0", busy); end
        op_rdy = 1; tick();
        n_cmp++; if (op !== 16'h2222) begin n_err++; $display("FAIL basic_op1 got %h want 2222", op); end
        n_cmp++; if (op_pc !== 32'h102) begin n_err++; $display("FAIL basic_pc1 got %h want 102", op_pc); end
        tick(); idle();
        n_cmp++; if (op_vld !== 1'b0) begin n_err++; $display("FAIL basic_empty got %b want 0", op_vld); end
    endtask

    task automatic test_misaligned();
        flush = 1; flush_pc = 32'h102; tick(); idle();
        n_cmp++; if (fq_addr !== 32'h100) begin n_err++; $display("FAIL mis_addr got %h want 100", fq_addr); end
        fq_ack = 1; tick(); idle(); tick();
        fq_rvld = 1; fq_rdata = 32'hAAAABBBB; tick(); idle();
        n_cmp++; if (op !== 16'hBBBB) begin n_err++; $display("FAIL mis_op got %h want bbbb", op); end
        n_cmp++; if (op_pc !== 32'h102) begin n_err++; $display("FAIL mis_pc got %h want 102", op_pc); end
        n_cmp++; if (fq_addr !== 32'h104) begin n_err++; $display("FAIL mis_next got %h want 104", fq_addr); end
        op_rdy = 1; tick(); idle();
        n_cmp++; if (op_vld !== 1'b0) begin n_err++; $display("FAIL mis_single got %b want 0", op_vld); end
        n_cmp++; if (fq_req !== 1'b1) begin n_err++; $display("FAIL mis_req got %b want 1", fq_req); end
    endtask

    task automatic test_full();
        flush = 1; flush_pc = 32'h200; tick(); idle();
        fq_ack = 1; tick(); idle();
        fq_rvld = 1; fq_rdata = 32'h01020304; tick(); idle();
        n_cmp++; if (fq_req !== 1'b1) begin n_err++; $display("FAIL full_req2 got %b want 1", fq_req); end
        fq_ack = 1; tick(); idle();
        fq_rvld = 1; fq_rdata = 32'h05060708; tick(); idle();
        n_cmp++; if (fq_req !== 1'b0) begin n_err++; $display("FAIL full_noreq got %b want 0", fq_req); end
        n_cmp++; if (fq_addr !== 32'h208) begin n_err++; $display("FAIL full_addr got %h want 208", fq_addr); end
        n_cmp++; if (op !== 16'h0102) begin n_err++; $display("FAIL full_head got %h want 0102", op); end
        tick(); tick();
        n_cmp++; if (fq_req !== 1'b0) begin n_err++; $display("FAIL full_hold got %b want 0", fq_req); end
        op_rdy = 1; tick(); idle();
        n_cmp++; if (fq_req !== 1'b0) begin n_err++; $display("FAIL full_pop1_req got %b want 0", fq_req); end
        n_cmp++; if (op !== 16'h0304) begin n_err++; $display("FAIL full_pop1_op got %h want 0304", op); end
        n_cmp++; if (op_pc !== 32'h202) begin n_err++; $display("FAIL full_pop1_pc got %h want 202", op_pc); end
        op_rdy = 1; tick(); idle();
        n_cmp++; if (fq_req !== 1'b1) begin n_err++; $display("FAIL full_pop2_req got %b want 1", fq_req); end
        n_cmp++; if (op !== 16'h0506) begin n_err++; $display("FAIL full_pop2_op got %h want 0506", op); end
    endtask

    task automatic test_discard();
        flush = 1; flush_pc = 32'h300; tick(); idle();
        fq_ack = 1; tick(); idle(); tick();
        flush = 1; flush_pc = 32'h404; tick(); idle();
        n_cmp++; if (fq_req !== 1'b0) begin n_err++; $display("FAIL disc_req got %b want 0", fq_req); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL disc_busy got %b want 1", busy); end
        tick();
        fq_rvld = 1; fq_rdata = 32'hDEADBEEF; tick(); idle();
        n_cmp++; if (op_vld !== 1'b0) begin n_err++; $display("FAIL disc_vld got %b want 0", op_vld); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL disc_clr got %b want 0", busy); end
        n_cmp++; if (fq_req !== 1'b1) begin n_err++; $display("FAIL disc_refetch got %b want 1", fq_req); end
        n_cmp++; if (fq_addr !== 32'h404) begin n_err++; $display("FAIL disc_addr got %h want 404", fq_addr); end
        flush = 1; flush_pc = 32'h500; fq_ack = 1; tick(); idle();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL disc_ack_busy got %b want 1", busy); end
        fq_rvld = 1; fq_rdata = 32'hCAFEF00D; tick(); idle();
        n_cmp++; if (op_vld !== 1'b0) begin n_err++; $display("FAIL disc_ack_vld got %b want 0", op_vld); end
        n_cmp++; if (fq_addr !== 32'h500) begin n_err++; $display("FAIL disc_ack_addr got %h want 500", fq_addr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        logic [31:0] faddr;
        logic        pend;
        int          pops;
        exp_pc = 32'hFFFF_FFF8; faddr = 32'hFFFF_FFF8;
        pend = 0; pops = 0;
        flush = 1; flush_pc = exp_pc; tick(); idle();
        for (int i = 0; i < 30; i++) begin
            if (op_vld) begin
                n_cmp++;
                if (op !== op_at(exp_pc) || op_pc !== exp_pc) begin
                    n_err++;
                    $display("FAIL b2b_op got %h@%h want %h@%h", op, op_pc, op_at(exp_pc), exp_pc);
                end
                exp_pc += 2; pops++;
            end
            if (fq_req) begin
                n_cmp++;
                if (fq_addr !== faddr) begin n_err++; $display("FAIL b2b_addr got %h want %h", fq_addr, faddr); end
            end
            fq_rvld = pend;
            fq_rdata = {op_at(faddr), op_at(faddr + 2)};
            if (pend) faddr += 4;
            fq_ack = fq_req;
            pend = fq_req;
            op_rdy = 1;
            tick();
        end
        idle();
        fq_rvld = pend; fq_rdata = {op_at(faddr), op_at(faddr + 2)};
        tick(); idle();
        n_cmp++; if (pops < 20) begin n_err++; $display("FAIL b2b_pops got %0d want >=20", pops); end
    endtask

    task automatic test_reset_mid();
        flush = 1; flush_pc = 32'h600; tick(); idle();
        fq_ack = 1; tick(); idle();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy got %b want 1", busy); end
        rst = 1; tick(); rst = 0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy0 got %b want 0", busy); end
        n_cmp++; if (fq_addr !== 32'h0) begin n_err++; $display("FAIL rmid_addr got %h want 0", fq_addr); end
        n_cmp++; if (op_pc !== 32'h0) begin n_err++; $display("FAIL rmid_pc got %h want 0", op_pc); end
        n_cmp++; if (fq_req !== 1'b0) begin n_err++; $display("FAIL rmid_req got %b want 0", fq_req); end
        fq_rvld = 1; fq_rdata = 32'h12345678; tick(); idle();
        n_cmp++; if (op_vld !== 1'b0) begin n_err++; $display("FAIL rmid_stray got %b want 0", op_vld); end
        n_cmp++; if (op !== 16'h0) begin n_err++; $display("FAIL rmid_op got %h want 0", op); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] mq[$];
        logic [31:0] m_faddr, m_paddr, fpc;
        logic        m_active, m_skip, m_pend, m_stale;
        logic        exp_vld, exp_req, rv, ack, rdy, fl;
        int          delay;
        m_active = 0; m_skip = 0; m_pend = 0; m_stale = 0;
        m_faddr = '0; m_paddr = '0; delay = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_vld = (mq.size() != 0);
            exp_req = m_active && !m_pend &&
                      ((DEPTH - mq.size()) >= (m_skip ? 1 : 2));
            n_cmp++; if (op_vld !== exp_vld) begin n_err++; $display("FAIL rnd_vld c%0d got %b want %b", cyc, op_vld, exp_vld); end
            n_cmp++; if (fq_req !== exp_req) begin n_err++; $display("FAIL rnd_req c%0d got %b want %b", cyc, fq_req, exp_req); end
            n_cmp++; if (busy !== m_pend) begin n_err++; $display("FAIL rnd_busy c%0d got %b want %b", cyc, busy, m_pend); end
            if (exp_req) begin
                n_cmp++; if (fq_addr !== m_faddr) begin n_err++; $display("FAIL rnd_addr c%0d got %h want %h", cyc, fq_addr, m_faddr); end
            end
            if (exp_vld) begin
                n_cmp++;
                if (op !== op_at(mq[0]) || op_pc !== mq[0]) begin
                    n_err++;
                    $display("FAIL rnd_op c%0d got %h@%h want %h@%h", cyc, op, op_pc, op_at(mq[0]), mq[0]);
                end
            end
            idle();
            rv  = m_pend && (delay == 0);
            ack = exp_req && ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 3) != 0);
            fl  = (cyc == 0) || (!rv && ($urandom_range(0, 23) == 0));
            fpc = $urandom;
            fq_rvld = rv;
            fq_rdata = {op_at(m_paddr), op_at(m_paddr + 2)};
            fq_ack = ack;
            op_rdy = rdy;
            flush = fl;
            flush_pc = fpc;
            tick();
            if (fl) begin
                mq.delete();
                m_active = 1;
                m_skip = fpc[1];
                m_faddr = {fpc[31:2], 2'b00};
                if (ack) begin
                    m_pend = 1; m_stale = 1;
                    delay = $urandom_range(0, 2);
                end else if (m_pend) begin
                    m_stale = 1;
                    if (delay > 0) delay--;
                end
            end else begin
                if (rdy && mq.size() != 0) void'(mq.pop_front());
                if (rv) begin
                    m_pend = 0;
                    if (m_stale) begin
                        m_stale = 0;
                    end else begin
                        if (!m_skip) mq.push_back(m_paddr);
                        mq.push_back(m_paddr + 2);
                        m_skip = 0;
                        m_faddr += 4;
                    end
                end else if (m_pend && delay > 0) begin
                    delay--;
                end
                if (ack) begin
                    m_pend = 1;
                    m_paddr = m_faddr;
                    delay = $urandom_range(0, 2);
                end
            end
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_basic();
        test_misaligned();
        test_full();
        test_discard();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
